// File: rtl/approx_err_sweep_ctrl.sv
// Exhaustive exact-vs-approximate error sweep sequencer.
// Ports: clk/rst, start/et in; vec/vec_valid out; exact_out/approx_out in;
//   busy/done status; max_err, err_cnt, err_sum, first_fail_vec/valid, pass.
module approx_err_sweep_ctrl #(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 2,
  parameter int LAT        = 0,
  parameter int EARLY_STOP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_OUT-1:0]      et,
  output logic [N_IN-1:0]       vec,
  output logic                  vec_valid,
  input  logic [N_OUT-1:0]      exact_out,
  input  logic [N_OUT-1:0]      approx_out,
  output logic                  busy,
  output logic                  done,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_IN:0]         err_cnt,
  output logic [N_IN+N_OUT-1:0] err_sum,
  output logic [N_IN-1:0]       first_fail_vec,
  output logic                  first_fail_valid,
  output logic                  pass
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DLAST = DW'((LAT > 0) ? LAT - 1 : 0);
  localparam state_t AFTER = (LAT > 0) ? DRAIN : DONE;

  state_t state_q, state_d;
  logic [N_IN-1:0] vec_q;
  logic [N_OUT-1:0] et_q;
  logic [DW-1:0] drain_cnt;
  logic tap_v;
  logic [N_IN-1:0] tap_vec;
  logic [N_OUT-1:0] err;
  logic fail, stop, accept;

  assign vec = vec_q;
  assign err = (exact_out >= approx_out) ?
               exact_out - approx_out :
               approx_out - exact_out;
  assign fail = tap_v && (err > et_q);
  assign stop = (EARLY_STOP != 0) && fail;
  assign accept = (state_q == IDLE) && start;

  // Delay line aligns each issued vector with its sampled outputs.
  if (LAT > 0) begin : g_pipe
    logic [LAT-1:0] pv;
    logic [N_IN-1:0] pvec [LAT];
    always_ff @(posedge clk) begin
      if (rst) begin
        pv <= '0;
        for (int i = 0; i < LAT; i++) pvec[i] <= '0;
      end else begin
        pv[0] <= vec_valid;
        pvec[0] <= vec_q;
        for (int i = 1; i < LAT; i++) begin
          pv[i] <= pv[i-1];
          pvec[i] <= pvec[i-1];
        end
      end
    end
    assign tap_v = pv[LAT-1];
    assign tap_vec = pvec[LAT-1];
  end else begin : g_comb
    assign tap_v = vec_valid;
    assign tap_vec = vec_q;
  end

  always_comb begin
    state_d = state_q;
    vec_valid = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = ISSUE;
      ISSUE: begin
        vec_valid = 1'b1;
        busy = 1'b1;
        if ((&vec_q) || stop) state_d = AFTER;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DLAST) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
      et_q <= '0;
      drain_cnt <= '0;
    end else begin
      if (state_q == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else drain_cnt <= '0;
      if (accept) begin
        vec_q <= '0;
        et_q <= et;
      end else if (state_q == ISSUE && state_d == ISSUE) begin
        vec_q <= vec_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      max_err <= '0;
      err_cnt <= '0;
      err_sum <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
      pass <= 1'b1;
    end else if (tap_v) begin
      if (err > max_err) max_err <= err;
      err_cnt <= err_cnt + (N_IN+1)'(err != '0);
      err_sum <= err_sum + (N_IN+N_OUT)'(err);
      if (fail && !first_fail_valid) begin
        first_fail_vec <= tap_vec;
        first_fail_valid <= 1'b1;
        pass <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_approx_err_sweep_ctrl.sv
// Self-checking bench: three configurations (LAT0, LAT2, early stop)
// against a table-driven reference sweep model.
module tb_approx_err_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0;
  logic [1:0] et = '0;
  logic [3:0] vec [3];
  logic vv [3];
  logic busy [3];
  logic done [3];
  logic ffval [3];
  logic pass [3];
  logic [1:0] ex [3];
  logic [1:0] ap [3];
  logic [1:0] mx [3];
  logic [4:0] cnt [3];
  logic [5:0] sum [3];
  logic [3:0] ffv [3];
  logic [1:0] tex [16];
  logic [1:0] tap [16];
  logic [1:0] e1, e2, a1, a2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign ex[0] = tex[vec[0]];
  assign ap[0] = tap[vec[0]];
  assign ex[2] = tex[vec[2]];
  assign ap[2] = tap[vec[2]];

  always @(posedge clk) begin
    e1 <= tex[vec[1]];
    e2 <= e1;
    a1 <= tap[vec[1]];
    a2 <= a1;
  end
  assign ex[1] = e2;
  assign ap[1] = a2;

  approx_err_sweep_ctrl #(.N_IN(4), .N_OUT(2), .LAT(0), .EARLY_STOP(0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .et(et),
    .vec(vec[0]), .vec_valid(vv[0]),
    .exact_out(ex[0]), .approx_out(ap[0]),
    .busy(busy[0]), .done(done[0]), .max_err(mx[0]),
    .err_cnt(cnt[0]), .err_sum(sum[0]),
    .first_fail_vec(ffv[0]), .first_fail_valid(ffval[0]),
    .pass(pass[0]));

  approx_err_sweep_ctrl #(.N_IN(4), .N_OUT(2), .LAT(2), .EARLY_STOP(0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .et(et),
    .vec(vec[1]), .vec_valid(vv[1]),
    .exact_out(ex[1]), .approx_out(ap[1]),
    .busy(busy[1]), .done(done[1]), .max_err(mx[1]),
    .err_cnt(cnt[1]), .err_sum(sum[1]),
    .first_fail_vec(ffv[1]), .first_fail_valid(ffval[1]),
    .pass(pass[1]));

  approx_err_sweep_ctrl #(.N_IN(4), .N_OUT(2), .LAT(0), .EARLY_STOP(1)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .et(et),
    .vec(vec[2]), .vec_valid(vv[2]),
    .exact_out(ex[2]), .approx_out(ap[2]),
    .busy(busy[2]), .done(done[2]), .max_err(mx[2]),
    .err_cnt(cnt[2]), .err_sum(sum[2]),
    .first_fail_vec(ffv[2]), .first_fail_valid(ffval[2]),
    .pass(pass[2]));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: walk the vectors in order, stop LAT vectors past the
  // first failure when early stop is on.
  int m_mx, m_cnt, m_sum, m_ffv, m_ffval, m_last, m_dc;
  task automatic model(input int lat, input bit es, input int etv);
    int stop_at, e;
    m_mx = 0; m_cnt = 0; m_sum = 0; m_ffv = 0; m_ffval = 0;
    stop_at = -1;
    for (int v = 0; v < 16; v++) begin
      if (stop_at >= 0 && v > stop_at + lat) break;
      e = int'(tex[v]) - int'(tap[v]);
      if (e < 0) e = -e;
      if (e > m_mx) m_mx = e;
      if (e != 0) m_cnt++;
      m_sum += e;
      if (e > etv && m_ffval == 0) begin
        m_ffv = v;
        m_ffval = 1;
      end
      if (es && stop_at < 0 && e > etv) stop_at = v;
    end
    m_last = 15;
    if (stop_at >= 0 && stop_at + lat < 15) m_last = stop_at + lat;
    m_dc = m_last + 1 + lat + 1;
  endtask

  task automatic check_results(input int i, input string tag);
    chk({tag, ".max_err"}, int'(mx[i]), m_mx);
    chk({tag, ".err_cnt"}, int'(cnt[i]), m_cnt);
    chk({tag, ".err_sum"}, int'(sum[i]), m_sum);
    chk({tag, ".ffv"}, int'(ffv[i]), m_ffv);
    chk({tag, ".ffvalid"}, int'(ffval[i]), m_ffval);
    chk({tag, ".pass"}, int'(pass[i]), m_ffval == 0 ? 1 : 0);
  endtask

  task automatic run(input int i, input logic [1:0] etv,
                     input bit hold, input string tag);
    int cyc, nv, lastv;
    bit got_done;
    model(i == 1 ? 2 : 0, i == 2, int'(etv));
    @(negedge clk);
    et = etv;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start[i] = 1'b0;
      et = ~etv;
    end
    cyc = 0; nv = 0; lastv = 0; got_done = 1'b0;
    while (!got_done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (vv[i]) begin
        chk({tag, ".vec"}, int'(vec[i]), nv);
        nv++;
        lastv = cyc;
      end
      if (done[i]) got_done = 1'b1;
    end
    chk({tag, ".done_cyc"}, cyc, m_dc);
    chk({tag, ".n_vec"}, nv, m_last + 1);
    chk({tag, ".last_valid_cyc"}, lastv, m_last + 1);
    chk({tag, ".busy_at_done"}, int'(busy[i]), 0);
    check_results(i, tag);
  endtask

  task automatic clean_tables();
    for (int v = 0; v < 16; v++) begin
      tex[v] = 2'(v & 3) >= 2'(v >> 2) ? 2'((v & 3) - (v >> 2))
                                       : 2'((v >> 2) - (v & 3));
      tap[v] = tex[v];
    end
  endtask

  initial begin
    clean_tables();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.pass", int'(pass[0]), 1);
    chk("reset.busy", int'(busy[0]), 0);
    chk("reset.err_cnt", int'(cnt[0]), 0);
    chk("reset.vec_valid", int'(vv[0]), 0);

    run(0, 2'd0, 1'b0, "clean");

    tex[5] = 2'd3; tap[5] = 2'd0;
    tex[9] = 2'd1; tap[9] = 2'd2;
    run(0, 2'd0, 1'b0, "mm_et0");
    run(0, 2'd3, 1'b0, "mm_et3");
    run(1, 2'd0, 1'b0, "lat2");
    run(2, 2'd0, 1'b0, "estop");

    // Reset in the middle of a sweep.
    @(negedge clk);
    start[0] = 1'b1;
    et = 2'd0;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst.busy", int'(busy[0]), 0);
    chk("rst.done", int'(done[0]), 0);
    chk("rst.vec_valid", int'(vv[0]), 0);
    chk("rst.err_cnt", int'(cnt[0]), 0);
    chk("rst.max_err", int'(mx[0]), 0);
    chk("rst.err_sum", int'(sum[0]), 0);
    chk("rst.pass", int'(pass[0]), 1);
    chk("rst.ffvalid", int'(ffval[0]), 0);
    clean_tables();
    run(0, 2'd0, 1'b0, "post_rst");

    // Start held high across a whole sweep.
    tex[5] = 2'd3; tap[5] = 2'd0;
    tex[9] = 2'd1; tap[9] = 2'd2;
    run(0, 2'd0, 1'b1, "hold");
    @(negedge clk);
    chk("hold.idle_busy", int'(busy[0]), 0);
    chk("hold.idle_cnt", int'(cnt[0]), m_cnt);
    @(negedge clk);
    chk("hold.restart_busy", int'(busy[0]), 1);
    chk("hold.restart_vec", int'(vec[0]), 0);
    chk("hold.restart_cnt", int'(cnt[0]), 0);
    start[0] = 1'b0;
    begin
      int k;
      k = 0;
      while (!done[0] && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("hold.second_done", int'(done[0]), 1);
      check_results(0, "hold2");
    end

    // Randomized tables and thresholds over all configurations.
    for (int r = 0; r < 9; r++) begin
      for (int v = 0; v < 16; v++) begin
        tex[v] = 2'($urandom_range(0, 3));
        tap[v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3))
                                             : tex[v];
      end
      run(r % 3, 2'($urandom_range(0, 3)), 1'b0, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
